// File: rtl/mult_issue.sv
// mult_issue: issues one RISC-V M-extension op to a multi-cycle multiplier and returns its result
// Optional feature: define MULT_ISSUE_ZERO_BYPASS_EN to answer zero-operand legal ops without the multiplier
module mult_issue #(
    parameter int TIMEOUT  = 63,
    parameter int ARM_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_funct3,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd_idx,
    output logic        mul_enable,
    output logic [31:0] mul_rs1,
    output logic [31:0] mul_rs2,
    output logic [11:0] mul_funct3,
    input  logic [31:0] mul_rd,
    input  logic        mul_done,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_idx,
    output logic        wb_err
);
    localparam int CMAX = (TIMEOUT > ARM_WAIT) ? TIMEOUT : ARM_WAIT;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
    logic [11:0]   f3_q, f3_d;
    logic [4:0]    idx_q, idx_d;
    logic          err_q, err_d, rdy_q, en_q, vld_q;
    logic          legal, skip;

    assign legal = in_funct3 inside {12'h433, 12'h4B3, 12'h533, 12'h5B3};
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    assign skip = !legal || in_rs1 == '0 || in_rs2 == '0;
`else
    assign skip = !legal;
`endif

    assign in_ready   = rdy_q;
    assign mul_enable = en_q;
    assign wb_valid   = vld_q;
    assign mul_rs1    = rs1_q;
    assign mul_rs2    = rs2_q;
    assign mul_funct3 = f3_q;
    assign wb_data    = data_q;
    assign wb_idx     = idx_q;
    assign wb_err     = err_q;

    // Next-state logic; the shared counter saturates and is cleared on every ARM/RUN entry
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CW'(CMAX)) ? cnt_q : cnt_q + 1'b1;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        idx_d   = idx_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (in_valid) begin
                rs1_d   = in_rs1;
                rs2_d   = in_rs2;
                f3_d    = in_funct3;
                idx_d   = in_rd_idx;
                data_d  = '0;
                err_d   = !legal;
                cnt_d   = '0;
                state_d = skip ? RESP : ARM;
            end
            ARM: if (!mul_done) begin
                state_d = RUN;
                cnt_d   = '0;
            end else if (cnt_q >= CW'(ARM_WAIT - 1)) begin
                state_d = RESP;
                data_d  = mul_rd;
                err_d   = 1'b0;
            end
            RUN: if (mul_done) begin
                state_d = RESP;
                data_d  = mul_rd;
                err_d   = 1'b0;
            end else if (cnt_q >= CW'(TIMEOUT - 1)) begin
                state_d = RESP;
                data_d  = '0;
                err_d   = 1'b1;
            end
            RESP: state_d = wb_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State, latched operands/result and handshake outputs, all registered from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            f3_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            en_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rdy_q   <= state_d == IDLE;
            en_q    <= state_d == ARM || state_d == RUN;
            vld_q   <= state_d == RESP;
        end
    end
endmodule

// File: tb/tb_mult_issue.sv
// tb_mult_issue: directed table, corner sequences and random ops against a behavioural multiplier model
module tb_mult_issue;
    localparam int TIMEOUT = 63, ARM_WAIT = 3;

    logic        clk = 0, reset = 1, in_valid = 0, wb_ready = 0;
    logic [11:0] in_funct3 = 0;
    logic [31:0] in_rs1 = 0, in_rs2 = 0;
    logic [4:0]  in_rd_idx = 0;
    logic        in_ready, mul_enable, wb_valid, wb_err;
    logic [31:0] mul_rs1, mul_rs2, wb_data;
    logic [11:0] mul_funct3;
    logic [31:0] mul_rd = 0;
    logic        mul_done = 1;
    logic [4:0]  wb_idx;

    always #5 clk = ~clk;

    mult_issue #(.TIMEOUT(TIMEOUT), .ARM_WAIT(ARM_WAIT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_idx(in_rd_idx),
        .mul_enable(mul_enable), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_funct3(mul_funct3),
        .mul_rd(mul_rd), .mul_done(mul_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_idx(wb_idx), .wb_err(wb_err)
    );

    int n_cmp = 0, n_bad = 0;
    int m_d = 0, m_len = 4, en_cnt = 0, en_cycles = 0;
    logic overlap = 0;

    function automatic logic is_legal(input logic [11:0] f);
        return f == 12'h433 || f == 12'h4B3 || f == 12'h533 || f == 12'h5B3;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, ua, sb, ub, p;
        sa = {{32{a[31]}}, a};
        ua = {32'b0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        case (f)
            12'h433: begin p = sa * sb; return p[31:0];  end
            12'h4B3: begin p = sa * sb; return p[63:32]; end
            12'h533: begin p = sa * ub; return p[63:32]; end
            12'h5B3: begin p = ua * ub; return p[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic skips_mul(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
        return !is_legal(f) || a == 0 || b == 0;
`else
        return !is_legal(f);
`endif
    endfunction

    // Multiplier model: done drops m_d cycles into Enable, stays low m_len cycles, result always the product
    always @(posedge clk) begin
        if (!mul_enable) begin
            en_cnt   <= 0;
            mul_done <= 1'b1;
        end else begin
            en_cnt   <= en_cnt + 1;
            mul_done <= !((en_cnt + 1 > m_d) && (en_cnt + 1 <= m_d + m_len));
        end
        mul_rd <= ref_mul(mul_funct3, mul_rs1, mul_rs2);
    end

    // Enable-cycle counter per transaction and valid/ready overlap detector
    always @(negedge clk) begin
        if (in_valid && in_ready) en_cycles <= 0;
        else if (mul_enable) en_cycles <= en_cycles + 1;
        if (wb_valid && in_ready) overlap <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic [11:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] idx,
                       input int hold, input logic [31:0] exp_d, input logic exp_e);
        int n;
        logic sk;
        sk = skips_mul(f, a, b);
        n = 0;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        chk("ready_before_issue", in_ready, 1);
        in_valid = 1; in_funct3 = f; in_rs1 = a; in_rs2 = b; in_rd_idx = idx; wb_ready = 0;
        @(posedge clk); #1;
        in_valid = 0; in_rs1 = $urandom; in_rs2 = $urandom; in_rd_idx = 5'($urandom);
        n = 0;
        while (!wb_valid && n < 300) begin @(posedge clk); #1; n++; end
        chk("wb_valid_arrives", wb_valid, 1);
        chk("wb_data", wb_data, exp_d);
        chk("wb_idx", wb_idx, idx);
        chk("wb_err", wb_err, exp_e);
        chk("latched_rs1", mul_rs1, a);
        chk("latched_rs2", mul_rs2, b);
        chk("latched_funct3", mul_funct3, f);
        chk("resp_one_cycle_if_no_mul", n == 0, sk);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", wb_valid, 1);
            chk("hold_data", wb_data, exp_d);
            chk("hold_idx", wb_idx, idx);
            chk("hold_in_ready", in_ready, 0);
        end
        wb_ready = 1;
        @(posedge clk); #1;
        wb_ready = 0;
        chk("idle_after_handshake", in_ready, 1);
        chk("wb_valid_dropped", wb_valid, 0);
        chk("enable_used", en_cycles != 0, !sk);
    endtask

    typedef struct {
        logic [11:0] f;
        logic [31:0] a, b;
        logic [4:0]  idx;
        int          hold;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl[10];
    logic [11:0] ops[4];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] f;
        logic [31:0] a, b;
        logic saw;
        tbl[0] = '{12'h433, 32'd5,        32'd3,        5'd7,  0,  32'd15,        1'b0};
        tbl[1] = '{12'h5B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  10, 32'hFFFFFFFE,  1'b0};
        tbl[2] = '{12'h4B3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  0,  32'h0,         1'b0};
        tbl[3] = '{12'h533, 32'hFFFFFFFF, 32'd2,        5'd3,  2,  32'hFFFFFFFF,  1'b0};
        tbl[4] = '{12'h033, 32'd1,        32'd1,        5'd4,  0,  32'h0,         1'b1};
        tbl[5] = '{12'h433, 32'd0,        32'd12345,    5'd5,  0,  32'h0,         1'b0};
        tbl[6] = '{12'h433, 32'h10000,    32'h10000,    5'd31, 0,  32'h0,         1'b0};
        tbl[7] = '{12'h4B3, 32'h80000000, 32'h80000000, 5'd0,  1,  32'h40000000,  1'b0};
        tbl[8] = '{12'h5B3, 32'h80000000, 32'd2,        5'd9,  0,  32'h1,         1'b0};
        tbl[9] = '{12'h7FF, 32'd6,        32'd7,        5'd11, 3,  32'h0,         1'b1};
        ops = '{12'h433, 12'h4B3, 12'h533, 12'h5B3};

        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_idx", wb_idx, 0);
        chk("rst_mul_enable", mul_enable, 0);
        chk("rst_mul_rs1", mul_rs1, 0);
        chk("rst_mul_funct3", mul_funct3, 0);

        m_d = 0; m_len = 4;
        for (int i = 0; i < 10; i++)
            txn(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].idx, tbl[i].hold, tbl[i].exp_d, tbl[i].exp_e);

        m_d = 0; m_len = 1000;
        txn(12'h433, 32'd3, 32'd4, 5'd9, 0, 32'h0, 1'b1);
        chk("timeout_enable_cycles", en_cycles, TIMEOUT + 2);

        m_d = 1000; m_len = 1;
        txn(12'h433, 32'd6, 32'd7, 5'd12, 0, 32'd42, 1'b0);
        chk("arm_wait_enable_cycles", en_cycles, ARM_WAIT);
        txn(12'h5B3, 32'd0, 32'd0, 5'd13, 0, 32'd0, 1'b0);
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
        chk("zero_bypass_enable_cycles", en_cycles, 0);
`else
        chk("zero_arm_wait_enable_cycles", en_cycles, ARM_WAIT);
`endif

        m_d = 0; m_len = 1000;
        @(posedge clk); #1;
        in_valid = 1; in_funct3 = 12'h433; in_rs1 = 9; in_rs2 = 9; in_rd_idx = 3;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #1 chk("enable_in_run", mul_enable, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("midrun_rst_enable", mul_enable, 0);
        chk("midrun_rst_valid", wb_valid, 0);
        chk("midrun_rst_in_ready", in_ready, 1);
        chk("midrun_rst_wb_data", wb_data, 0);
        chk("midrun_rst_mul_rs1", mul_rs1, 0);
        saw = 0;
        repeat (10) begin @(posedge clk); #1; if (wb_valid) saw = 1; end
        chk("midrun_rst_no_wb", saw, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                f = 12'($urandom);
                while (is_legal(f)) f = 12'($urandom);
            end else f = ops[$urandom_range(0, 3)];
            a = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            m_d = $urandom_range(0, ARM_WAIT - 2);
            m_len = $urandom_range(1, 20);
            txn(f, a, b, 5'($urandom), $urandom_range(0, 3), is_legal(f) ? ref_mul(f, a, b) : 32'h0, !is_legal(f));
        end

        chk("valid_never_with_ready", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
